imem_access_arbiter: RTL and testbench

Arbitrates the single-port instruction memory between the core's fetch path and a program loader. After reset it holds the core in a boot phase in which only the loader may access the memory, then switches to run mode where fetch has priority and the loader is served in idle cycles or via an anti-starvation override. It decodes byte addresses to word indices, flags bad addresses, and returns read data with fixed one-cycle latency.

---
 rtl/imem_access_arbiter.sv | 145 ++++++++++++++
 tb/tb_imem_access_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_access_arbiter.sv
// Single-port instruction memory arbiter: loader-only BOOT phase, then RUN with
// fetch priority, loader anti-starvation override, address decode and 1-cycle responses.

module imem_addr_decode #(
    parameter int IDX_W = 5
) (
    input  logic [31:0]      addr,
    output logic [IDX_W-1:0] index,
    output logic             err
);
    assign index = addr[IDX_W+1:2];
    assign err   = (addr[1:0] != 2'b00) || (addr[31:IDX_W+2] != '0);
endmodule

module imem_access_arbiter #(
    parameter int IDX_W        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_req_valid,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_req_ready,
    output logic             fetch_rsp_valid,
    output logic [31:0]      fetch_rsp_data,
    output logic             fetch_rsp_err,
    input  logic             ld_req_valid,
    input  logic             ld_we,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_wdata,
    output logic             ld_req_ready,
    output logic             ld_rsp_valid,
    output logic [31:0]      ld_rsp_data,
    output logic             ld_rsp_err,
    input  logic             ld_done,
    output logic             boot_mode,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_index,
    output logic [31:0]      mem_wdata,
    input  logic [31:31-31]  mem_rdata
);
    localparam int NUM_PORTS = 2;  // 0 = fetch, 1 = loader
    localparam int CNT_W     = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t     state, state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic       fetch_gnt, ld_gnt;

    logic [NUM_PORTS-1:0][31:0]      port_addr;
    logic [NUM_PORTS-1:0][IDX_W-1:0] port_idx;
    logic [NUM_PORTS-1:0]            port_err;

    // Response owner/kind is registered so a new access can overlap the response.
    logic f_pend, f_perr, l_pend, l_perr, l_pwe;

    assign port_addr = {ld_addr, fetch_addr};

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_dec
            imem_addr_decode #(.IDX_W(IDX_W)) u_dec (
                .addr  (port_addr[g]),
                .index (port_idx[g]),
                .err   (port_err[g])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (state == BOOT && ld_done) state_d = RUN;
    end

    // Grant and readies; reset forces everything quiet since readies are combinational.
    always_comb begin
        fetch_gnt       = 1'b0;
        ld_gnt          = 1'b0;
        fetch_req_ready = 1'b0;
        ld_req_ready    = 1'b0;
        boot_mode       = (state == BOOT);
        if (!reset) begin
            if (state == BOOT) begin
                ld_req_ready = 1'b1;
                ld_gnt       = ld_req_valid;
            end else begin
                if (ld_req_valid && starve_cnt == LIMIT) ld_gnt    = 1'b1;
                else if (fetch_req_valid)                fetch_gnt = 1'b1;
                else if (ld_req_valid)                   ld_gnt    = 1'b1;
                fetch_req_ready = fetch_gnt;
                ld_req_ready    = ld_gnt;
            end
        end
    end

    always_comb begin
        mem_en    = (fetch_gnt && !port_err[0]) || (ld_gnt && !port_err[1]);
        mem_we    = ld_gnt && ld_we && !port_err[1];
        mem_index = '0;
        if (fetch_gnt)   mem_index = port_idx[0];
        else if (ld_gnt) mem_index = port_idx[1];
        mem_wdata = (ld_gnt && ld_we) ? ld_wdata : 32'h0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == RUN && ld_req_valid && !ld_gnt) begin
            if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_pend <= 1'b0;
            f_perr <= 1'b0;
            l_pend <= 1'b0;
            l_perr <= 1'b0;
            l_pwe  <= 1'b0;
        end else begin
            f_pend <= fetch_gnt;
            f_perr <= fetch_gnt && port_err[0];
            l_pend <= ld_gnt;
            l_perr <= ld_gnt && port_err[1];
            l_pwe  <= ld_gnt && ld_we;
        end
    end

    assign fetch_rsp_valid = f_pend;
    assign fetch_rsp_err   = f_pend && f_perr;
    assign fetch_rsp_data  = (f_pend && !f_perr) ? mem_rdata : 32'h0;
    assign ld_rsp_valid    = l_pend;
    assign ld_rsp_err      = l_pend && l_perr;
    assign ld_rsp_data     = (l_pend && !l_perr && !l_pwe) ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them against the DUT response strobes.

module tb_imem_access_arbiter;
    localparam int IDX_W = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             fetch_req_valid = 1'b0;
    logic [31:0]      fetch_addr = '0;
    logic             fetch_req_ready, fetch_rsp_valid, fetch_rsp_err;
    logic [31:0]      fetch_rsp_data;
    logic             ld_req_valid = 1'b0, ld_we = 1'b0, ld_done = 1'b0;
    logic [31:0]      ld_addr = '0, ld_wdata = '0;
    logic             ld_req_ready, ld_rsp_valid, ld_rsp_err;
    logic [31:0]      ld_rsp_data;
    logic             boot_mode, mem_en, mem_we;
    logic [IDX_W-1:0] mem_index;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = '0;

    logic [31:0] mem [0:(1<<IDX_W)-1];
    logic [32:0] f_q[$];
    logic [32:0] l_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    imem_access_arbiter #(.IDX_W(IDX_W), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .fetch_req_valid(fetch_req_valid), .fetch_addr(fetch_addr),
        .fetch_req_ready(fetch_req_ready), .fetch_rsp_valid(fetch_rsp_valid),
        .fetch_rsp_data(fetch_rsp_data), .fetch_rsp_err(fetch_rsp_err),
        .ld_req_valid(ld_req_valid), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_req_ready(ld_req_ready), .ld_rsp_valid(ld_rsp_valid),
        .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err), .ld_done(ld_done),
        .boot_mode(boot_mode), .mem_en(mem_en), .mem_we(mem_we),
        .mem_index(mem_index), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Synchronous single-port memory model, read data one cycle after strobe.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_index] <= mem_wdata;
            else        mem_rdata <= mem[mem_index];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    always @(negedge clock) begin
        if (fetch_rsp_valid) begin
            if (f_q.size() == 0) chk("fetch_rsp_unexpected", 32'd1, 32'd0);
            else begin
                logic [32:0] e;
                e = f_q.pop_front();
                chk("fetch_rsp_data", fetch_rsp_data, e[31:0]);
                chk("fetch_rsp_err", {31'd0, fetch_rsp_err}, {31'd0, e[32]});
            end
        end
        if (ld_rsp_valid) begin
            if (l_q.size() == 0) chk("ld_rsp_unexpected", 32'd1, 32'd0);
            else begin
                logic [32:0] e;
                e = l_q.pop_front();
                chk("ld_rsp_data", ld_rsp_data, e[31:0]);
                chk("ld_rsp_err", {31'd0, ld_rsp_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic req_fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic exp_err, input logic exp_en,
                             input logic [IDX_W-1:0] exp_idx);
        fetch_req_valid = 1'b1;
        fetch_addr      = addr;
        @(negedge clock);
        chk("fetch_req_ready", {31'd0, fetch_req_ready}, 32'd1);
        chk("fetch_mem_en", {31'd0, mem_en}, {31'd0, exp_en});
        if (exp_en) chk("fetch_mem_index", {27'd0, mem_index}, {27'd0, exp_idx});
        f_q.push_back({exp_err, exp_data});
        step();
        fetch_req_valid = 1'b0;
    endtask

    task automatic req_ld(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic [IDX_W-1:0] exp_idx);
        ld_req_valid = 1'b1;
        ld_we        = we;
        ld_addr      = addr;
        ld_wdata     = wdata;
        @(negedge clock);
        chk("ld_req_ready", {31'd0, ld_req_ready}, 32'd1);
        chk("fetch_ready_low", {31'd0, fetch_req_ready}, 32'd0);
        chk("ld_mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("ld_mem_index", {27'd0, mem_index}, {27'd0, exp_idx});
        l_q.push_back({1'b0, exp_data});
        step();
        ld_req_valid = 1'b0;
        ld_we        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << IDX_W); i++) mem[i] = '0;

        // Reset state
        fetch_req_valid = 1'b1;
        ld_req_valid    = 1'b1;
        @(negedge clock);
        chk("rst_boot_mode", {31'd0, boot_mode}, 32'd1);
        chk("rst_ld_ready", {31'd0, ld_req_ready}, 32'd0);
        chk("rst_fetch_ready", {31'd0, fetch_req_ready}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        ld_req_valid = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ld_ready", {31'd0, ld_req_ready}, 32'd1);
        chk("post_rst_fetch_ready", {31'd0, fetch_req_ready}, 32'd0);
        step();

        // Boot load with fetch pending but blocked
        req_ld(1'b1, 32'h4, 32'h002081B3, 32'h0, 5'd1);
        fetch_req_valid = 1'b1;
        req_ld(1'b1, 32'h8, 32'h40308233, 32'h0, 5'd2);
        fetch_req_valid = 1'b0;

        // Run fetch
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        @(negedge clock);
        chk("run_boot_mode", {31'd0, boot_mode}, 32'd0);
        step();
        req_fetch(32'h4, 32'h002081B3, 1'b0, 1'b1, 5'd1);
        req_fetch(32'h8, 32'h40308233, 1'b0, 1'b1, 5'd2);
        req_ld(1'b0, 32'h4, 32'h0, 32'h002081B3, 5'd1);

        // Bad addresses
        req_fetch(32'h6,  32'h0, 1'b1, 1'b0, 5'd0);
        req_fetch(32'h80, 32'h0, 1'b1, 1'b0, 5'd0);

        // Starvation: F F F F L repeating
        fetch_req_valid = 1'b1;
        fetch_addr      = 32'h4;
        ld_req_valid    = 1'b1;
        ld_we           = 1'b0;
        ld_addr         = 32'h8;
        for (int c = 0; c < 10; c++) begin
            logic exp_ld;
            exp_ld = (c % 5) == 4;
            @(negedge clock);
            chk("starve_ld_ready", {31'd0, ld_req_ready}, {31'd0, exp_ld});
            chk("starve_fetch_ready", {31'd0, fetch_req_ready}, {31'd0, !exp_ld});
            if (ld_req_ready)    l_q.push_back({1'b0, 32'h40308233});
            if (fetch_req_ready) f_q.push_back({1'b0, 32'h002081B3});
            step();
        end
        ld_req_valid = 1'b0;

        // Reset mid-access: fetch accepted, reset before response edge
        @(negedge clock);
        chk("mid_fetch_ready", {31'd0, fetch_req_ready}, 32'd1);
        step();
        reset = 1'b1;
        fetch_req_valid = 1'b0;
        @(negedge clock);
        chk("mid_rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
        chk("mid_boot_mode", {31'd0, boot_mode}, 32'd1);
        chk("mid_ld_ready", {31'd0, ld_req_ready}, 32'd0);
        chk("mid_fetch_ready", {31'd0, fetch_req_ready}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // ld_done coincident with a loader write
        ld_done = 1'b1;
        req_ld(1'b1, 32'hC, 32'hDEADBEEF, 32'h0, 5'd3);
        ld_done = 1'b0;
        req_fetch(32'hC, 32'hDEADBEEF, 1'b0, 1'b1, 5'd3);
        chk("final_boot_mode", {31'd0, boot_mode}, 32'd0);

        step(); step();
        chk("fetch_q_empty", f_q.size(), 32'd0);
        chk("ld_q_empty", l_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
